store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffered stores; power of two, at least 2.
REQ-002 SHALL have parameter AW, default 32: address width in bits; addresses are word indices into data memory.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port st_valid, input, 1 bit: CPU store request.
REQ-006 SHALL have port st_addr, input, AW bits: store word address.
REQ-007 SHALL have port st_data, input, 32 bits: store data.
REQ-008 SHALL have port st_ready, output, 1 bit: buffer can accept a store this cycle.
REQ-009 SHALL have port ld_req, input, 1 bit: CPU load request, single-cycle.
REQ-010 SHALL have port ld_addr, input, AW bits: load word address.
REQ-011 SHALL have port ld_data, output, 32 bits: registered load result.
REQ-012 SHALL have port ld_done, output, 1 bit: ld_data valid this cycle.
REQ-013 SHALL have port ld_fwd, output, 1 bit: ld_data was forwarded from the buffer; valid with ld_done.
REQ-014 SHALL have port empty, output, 1 bit: no stores buffered.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of buffered stores.
REQ-016 SHALL have port mem_address, output, 32 bits: data memory address, zero-extended from AW.
REQ-017 SHALL have port mem_dataIn, output, 32 bits: data memory write data.
REQ-018 SHALL have port mem_memWrite, output, 1 bit: data memory write enable.
REQ-019 SHALL have port mem_memRead, output, 1 bit: data memory read enable.
REQ-020 SHALL have port mem_dataOut, input, 32 bits: data memory read data, combinational from mem_address.

Function
REQ-021 SHALL hold stores in a circular FIFO with head/tail pointers wrapping modulo DEPTH, plus count.
REQ-022 SHALL drive st_ready = (count < DEPTH) combinationally; a full buffer SHALL NOT accept a store even in a drain cycle (no full-bypass).
REQ-023 SHALL enqueue {st_addr, st_data} at the tail on a rising edge where st_valid && st_ready.
REQ-024 SHALL arbitrate the memory port each cycle with a combinational port state: LOAD if ld_req; else DRAIN if count>0; else IDLE.
REQ-025 In LOAD, SHALL drive mem_memRead=1, mem_memWrite=0, mem_address=ld_addr, mem_dataIn=0.
REQ-026 In DRAIN, SHALL drive mem_memWrite=1, mem_memRead=0, mem_address/mem_dataIn = head entry, and advance head at the edge.
REQ-027 In IDLE, SHALL drive all mem_* outputs to 0.
REQ-028 Loads SHALL have priority; continuous ld_req starves draining, which is permitted.
REQ-029 On a LOAD cycle, at the edge SHALL register ld_done=1, and ld_data = data of the youngest buffered entry whose address equals ld_addr (ld_fwd=1), else mem_dataOut (ld_fwd=0); latency exactly 1 cycle.
REQ-030 ld_done and ld_fwd SHALL be 0 in any cycle not following a LOAD cycle; ld_data SHALL hold its last value.
REQ-031 Back-to-back ld_req SHALL yield ld_done on each following cycle.
REQ-032 A store accepted in the same cycle as a load SHALL be ordered after that load: it is not forwarded to it.
REQ-033 Simultaneous enqueue and drain SHALL leave count unchanged; count SHALL otherwise increment on enqueue and decrement on drain.
REQ-034 empty SHALL equal (count == 0).
REQ-035 Memory writes SHALL occur in exact enqueue order, one per DRAIN cycle.

Reset
REQ-036 While reset is high, mem_memWrite and mem_memRead SHALL be forced to 0 combinationally.
REQ-037 At a rising edge with reset high, SHALL clear head, tail and count to 0, and clear ld_done, ld_fwd and ld_data to 0.
REQ-038 At reset, all buffered stores SHALL be discarded and never written; st_valid and ld_req are ignored during reset.

Verification
REQ-039 Reset, then st_valid with addr 10, data 0xAA, idle -> count=1 next cycle; next cycle mem_memWrite=1, mem_address=10, mem_dataIn=0xAA; then empty=1.
REQ-040 Memory word 80=8; ld_req addr 80 held high while issuing 5 stores -> 4 accepted, st_ready=0, count=4, ld_done=1, ld_data=8, ld_fwd=0 every cycle, no mem_memWrite.
REQ-041 Buffer stores (20,0x11) then (20,0x22); ld_req addr 20 -> next cycle ld_done=1, ld_data=0x22, ld_fwd=1.
REQ-042 Empty buffer, memory word 80=8; same-cycle store (80,0x5) and ld_req 80 -> ld_data=8, ld_fwd=0; later drain writes 0x5 to word 80.
REQ-043 Stream 10 stores (addr i, data i+1) at one per cycle with no loads -> pointers wrap, memory writes are addr 0..9 in order, final count=0.
REQ-044 With count=3, assert reset for 1 cycle -> mem_memWrite=0 during that cycle; next cycle count=0, empty=1; the 3 stores never appear on the memory port.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: circular store FIFO that drains to data memory, with load priority and store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [AW-1:0]          st_addr,
  input  logic [31:0]            st_data,
  output logic                   st_ready,
  input  logic                   ld_req,
  input  logic [AW-1:0]          ld_addr,
  output logic [31:0]            ld_data,
  output logic                   ld_done,
  output logic                   ld_fwd,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            mem_address,
  output logic [31:0]            mem_dataIn,
  output logic                   mem_memWrite,
  output logic                   mem_memRead,
  input  logic [31:0]            mem_dataOut
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} port_t;
  port_t ps;
  logic [AW-1:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic enq, drn, hit;
  logic [31:0] fwd;
  always_comb begin
    ps = ld_req ? LOAD : (count != '0) ? DRAIN : IDLE;
    st_ready = count < CW'(DEPTH);
    enq = st_valid && st_ready;
    drn = ps == DRAIN;
    empty = count == '0;
    mem_memRead = !reset && ps == LOAD;
    mem_memWrite = !reset && drn;
    mem_address = (ps == LOAD) ? 32'(ld_addr) : drn ? 32'(addr_q[head]) : '0;
    mem_dataIn = drn ? data_q[head] : '0;
  end
  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count && addr_q[head + PW'(i)] == ld_addr) begin
        hit = 1'b1;
        fwd = data_q[head + PW'(i)];
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      ld_done <= 1'b0;
      ld_fwd <= 1'b0;
      ld_data <= '0;
    end else begin
      if (enq) begin
        addr_q[tail] <= st_addr;
        data_q[tail] <= st_data;
        tail <= tail + 1'b1;
      end
      if (drn) head <= head + 1'b1;
      count <= count + CW'(enq) - CW'(drn);
      ld_done <= ps == LOAD;
      ld_fwd <= ps == LOAD && hit;
      if (ps == LOAD) ld_data <= hit ? fwd : mem_dataOut;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed table, corner sequences and random traffic against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, st_valid, st_ready, ld_req, ld_done, ld_fwd, empty;
  logic mem_memWrite, mem_memRead;
  logic [AW-1:0] st_addr, ld_addr;
  logic [31:0] st_data, ld_data, mem_address, mem_dataIn, mem_dataOut;
  logic [$clog2(DEPTH):0] count;
  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_done(ld_done), .ld_fwd(ld_fwd), .empty(empty), .count(count),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_memWrite(mem_memWrite),
    .mem_memRead(mem_memRead), .mem_dataOut(mem_dataOut)
  );
  logic [31:0] mem [256];
  assign mem_dataOut = mem[mem_address[7:0]];
  always @(posedge clk) if (mem_memWrite) mem[mem_address[7:0]] <= mem_dataIn;
  typedef struct {logic [31:0] a; logic [31:0] d;} ent_t;
  ent_t q[$];
  logic [31:0] m_data;
  logic m_done, m_fwd;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic rst; logic sv; logic [31:0] sa; logic [31:0] sd; logic lr; logic [31:0] la;
    int cnt; logic done; logic [31:0] data; logic fwd;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic rst, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic lr, input logic [31:0] la);
    int n;
    @(negedge clk);
    reset = rst; st_valid = sv; st_addr = sa; st_data = sd; ld_req = lr; ld_addr = la;
    #1;
    n = q.size();
    chk("st_ready", 32'(st_ready), 32'(n < DEPTH));
    chk("count", 32'(count), n);
    chk("empty", 32'(empty), 32'(n == 0));
    if (rst) begin
      chk("rst_memWrite", 32'(mem_memWrite), 0);
      chk("rst_memRead", 32'(mem_memRead), 0);
    end else if (lr) begin
      chk("ld_memRead", 32'(mem_memRead), 1);
      chk("ld_memWrite", 32'(mem_memWrite), 0);
      chk("ld_address", mem_address, la);
      chk("ld_dataIn", mem_dataIn, 0);
    end else if (n > 0) begin
      chk("dr_memWrite", 32'(mem_memWrite), 1);
      chk("dr_memRead", 32'(mem_memRead), 0);
      chk("dr_address", mem_address, q[0].a);
      chk("dr_dataIn", mem_dataIn, q[0].d);
    end else begin
      chk("idle_wr_rd", {30'd0, mem_memWrite, mem_memRead}, 0);
      chk("idle_addr_din", mem_address | mem_dataIn, 0);
    end
    if (rst) begin
      q.delete();
      m_done = 1'b0; m_fwd = 1'b0; m_data = '0;
    end else begin
      m_done = lr;
      m_fwd = 1'b0;
      if (lr) begin
        m_data = mem[la[7:0]];
        for (int i = 0; i < n; i++)
          if (q[i].a == la) begin m_data = q[i].d; m_fwd = 1'b1; end
      end
      if (!lr && n > 0) void'(q.pop_front());
      if (sv && n < DEPTH) q.push_back('{sa, sd});
    end
    @(posedge clk);
    #1;
    chk("ld_done", 32'(ld_done), 32'(m_done));
    chk("ld_fwd", 32'(ld_fwd), 32'(m_fwd));
    chk("ld_data", ld_data, m_data);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[80] = 32'd8;
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_req = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);
    tbl[0] = '{1, 0, 0,  0,     0, 0,  0, 0, 0,     0};
    tbl[1] = '{0, 1, 10, 'hAA,  0, 0,  1, 0, 0,     0};
    tbl[2] = '{0, 0, 0,  0,     0, 0,  0, 0, 0,     0};
    tbl[3] = '{0, 1, 20, 'h11,  1, 99, 1, 1, 0,     0};
    tbl[4] = '{0, 1, 20, 'h22,  1, 99, 2, 1, 0,     0};
    tbl[5] = '{0, 0, 0,  0,     1, 20, 2, 1, 'h22,  1};
    tbl[6] = '{0, 0, 0,  0,     0, 0,  1, 0, 'h22,  0};
    tbl[7] = '{0, 0, 0,  0,     0, 0,  0, 0, 'h22,  0};
    tbl[8] = '{0, 1, 80, 5,     1, 80, 1, 1, 8,     0};
    tbl[9] = '{0, 0, 0,  0,     0, 0,  0, 0, 8,     0};
    for (int v = 0; v < 10; v++) begin
      step(tbl[v].rst, tbl[v].sv, tbl[v].sa, tbl[v].sd, tbl[v].lr, tbl[v].la);
      chk("tbl_count", 32'(count), tbl[v].cnt);
      chk("tbl_done", 32'(ld_done), 32'(tbl[v].done));
      chk("tbl_data", ld_data, tbl[v].data);
      chk("tbl_fwd", 32'(ld_fwd), 32'(tbl[v].fwd));
    end
    chk("mem10", mem[10], 32'hAA);
    chk("mem20", mem[20], 32'h22);
    chk("mem80", mem[80], 32'h5);
    mem[80] = 32'd8;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 30 + i, 100 + i, 1, 80);
      chk("starve_done", 32'(ld_done), 1);
      chk("starve_data", ld_data, 8);
      chk("starve_fwd", 32'(ld_fwd), 0);
    end
    chk("full_ready", 32'(st_ready), 0);
    chk("full_count", 32'(count), 4);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_rst_count", 32'(count), 3);
    step(1, 1, 40, 1, 1, 40);
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_empty", 32'(empty), 1);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("mem30", mem[30], 100);
    for (int i = 31; i < 34; i++) chk("discarded", mem[i], 0);
    for (int i = 0; i < 10; i++) step(0, 1, i, i + 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("stream_count", 32'(count), 0);
    for (int i = 0; i < 10; i++) chk("stream_mem", mem[i], i + 1);
    for (int k = 0; k < 400; k++)
      step($urandom % 40 == 0, 1'($urandom % 2), $urandom % 8, $urandom,
           $urandom % 3 == 0, $urandom % 8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
